// File: rtl/cmac_tx_gate.sv
// -----------------------------------------------------------------------------
// cmac_tx_gate
//
// Gates the application's AXI-Stream TX traffic into the CMAC axis_tx port.
// It runs entirely in the tx_clk domain.
//
// Traffic only passes while PCS alignment has been held for ARM_CYCLES
// consecutive cycles. The gate never opens in the middle of an application
// frame. If alignment drops while a frame is in flight, the frame already
// started on the CMAC side is closed with a one-byte error beat (tuser=1, so
// the CMAC corrupts the FCS). The remainder of the application frame is then
// swallowed.
//
// Ports
//   tx_clk, tx_resetn    clock, async active-low reset
//   stat_rx_aligned      raw CMAC alignment status (async, synchronised here)
//   tx_in_*              AXI-Stream slave from the application
//   tx_out_*             AXI-Stream master to the CMAC (one-deep register)
//   tx_active            high while traffic is being passed
//   pkts_dropped         frames discarded whole while the link was down (sat.)
//   pkts_aborted         frames cut short with an error beat (saturating)
// -----------------------------------------------------------------------------
module cmac_tx_gate #(
   parameter int ARM_CYCLES     = 322266,
   parameter bit DROP_WHEN_DOWN = 1'b1
) (
   input  logic         tx_clk,
   input  logic         tx_resetn,
   input  logic         stat_rx_aligned,
   input  logic [511:0] tx_in_tdata,
   input  logic [63:0]  tx_in_tkeep,
   input  logic         tx_in_tlast,
   input  logic         tx_in_tvalid,
   output logic         tx_in_tready,
   output logic [511:0] tx_out_tdata,
   output logic [63:0]  tx_out_tkeep,
   output logic         tx_out_tlast,
   output logic         tx_out_tuser,
   output logic         tx_out_tvalid,
   input  logic         tx_out_tready,
   output logic         tx_active,
   output logic [31:0]  pkts_dropped,
   output logic [31:0]  pkts_aborted
);

   localparam int            CW       = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;
   localparam logic [CW-1:0] ARM_LAST = CW'(ARM_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_DOWN    = 3'd0,
      ST_ARM     = 3'd1,
      ST_PASS    = 3'd2,
      ST_ABORT   = 3'd3,
      ST_DISCARD = 3'd4
   } state_t;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [2:0]    sync_q;
   state_t        state_q,     state_d;
   logic [CW-1:0] arm_cnt_q,   arm_cnt_d;
   logic          in_mid_q,    in_mid_d;
   logic          out_valid_q, out_valid_d;
   logic [511:0]  out_data_q,  out_data_d;
   logic [63:0]   out_keep_q,  out_keep_d;
   logic          out_last_q,  out_last_d;
   logic          out_user_q,  out_user_d;
   logic [31:0]   dropped_q,   dropped_d;
   logic [31:0]   aborted_q,   aborted_d;

   logic aligned;
   logic in_ready;
   logic in_hs;
   logic out_fire;
   logic out_free;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (&v) ? v : v + 32'd1;
   endfunction

   // Three-flop synchroniser on the asynchronous alignment status.
   always_ff @(posedge tx_clk or negedge tx_resetn) begin
      if (!tx_resetn) sync_q <= 3'b000;
      else            sync_q <= {sync_q[1:0], stat_rx_aligned};
   end

   assign aligned  = sync_q[2];
   assign out_fire = out_valid_q & tx_out_tready;
   // The register can take a new beat when empty or when its beat leaves now.
   assign out_free = ~out_valid_q | tx_out_tready;

   // ---------------------------------------------------------------------------
   // Input ready per state
   // ---------------------------------------------------------------------------
   always_comb begin
      in_ready = 1'b0;
      case (state_q)
         ST_DOWN, ST_ARM: in_ready = DROP_WHEN_DOWN;
         ST_PASS:         in_ready = out_free;
         ST_ABORT:        in_ready = 1'b0;
         ST_DISCARD:      in_ready = 1'b1;
         default:         in_ready = 1'b0;
      endcase
   end

   assign in_hs = tx_in_tvalid & in_ready;

   // Frame tracking on the input side, independent of state. Every decision
   // that depends on in_mid uses the value updated by this cycle's beat.
   assign in_mid_d = in_hs ? ~tx_in_tlast : in_mid_q;

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      arm_cnt_d   = arm_cnt_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_keep_d  = out_keep_q;
      out_last_d  = out_last_q;
      out_user_d  = out_user_q;
      dropped_d   = dropped_q;
      aborted_d   = aborted_q;

      // A beat that leaves empties the register unless refilled below. This
      // applies in every state, so a held beat always drains.
      if (out_fire) out_valid_d = 1'b0;

      case (state_q)
         ST_DOWN: begin
            arm_cnt_d = '0;
            if (in_hs && tx_in_tlast) dropped_d = sat_inc(dropped_q);
            if (aligned) state_d = ST_ARM;
         end

         ST_ARM: begin
            if (in_hs && tx_in_tlast) dropped_d = sat_inc(dropped_q);
            if (!aligned) begin
               state_d   = ST_DOWN;
               arm_cnt_d = '0;
            end else if (arm_cnt_q == ARM_LAST) begin
               // The count is held here until the app is between frames, so
               // the first passed beat is always a start of frame.
               if (!in_mid_d) state_d = ST_PASS;
            end else begin
               arm_cnt_d = arm_cnt_q + 1'b1;
            end
         end

         ST_PASS: begin
            if (in_hs) begin
               out_valid_d = 1'b1;
               out_data_d  = tx_in_tdata;
               out_keep_d  = tx_in_tkeep;
               out_last_d  = tx_in_tlast;
               out_user_d  = 1'b0;
            end
            if (!aligned) state_d = in_mid_d ? ST_ABORT : ST_DOWN;
         end

         ST_ABORT: begin
            // Only the error beat ever carries tuser=1, so a valid register
            // with tuser set means the error beat is already loaded.
            if (out_valid_q && out_user_q) begin
               if (tx_out_tready) begin
                  aborted_d = sat_inc(aborted_q);
                  state_d   = ST_DISCARD;
               end
            end else if (out_free) begin
               out_valid_d = 1'b1;
               out_data_d  = '0;
               out_keep_d  = 64'h1;
               out_last_d  = 1'b1;
               out_user_d  = 1'b1;
            end
         end

         ST_DISCARD: begin
            if (in_hs && tx_in_tlast) state_d = ST_DOWN;
         end

         default: state_d = ST_DOWN;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge tx_clk or negedge tx_resetn) begin
      if (!tx_resetn) begin
         state_q     <= ST_DOWN;
         arm_cnt_q   <= '0;
         in_mid_q    <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_keep_q  <= '0;
         out_last_q  <= 1'b0;
         out_user_q  <= 1'b0;
         dropped_q   <= '0;
         aborted_q   <= '0;
      end else begin
         state_q     <= state_d;
         arm_cnt_q   <= arm_cnt_d;
         in_mid_q    <= in_mid_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_keep_q  <= out_keep_d;
         out_last_q  <= out_last_d;
         out_user_q  <= out_user_d;
         dropped_q   <= dropped_d;
         aborted_q   <= aborted_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   // Ready is forced low while reset is held so every output reads 0 in reset,
   // even when DOWN would otherwise accept and discard.
   assign tx_in_tready  = in_ready & tx_resetn;
   assign tx_out_tvalid = out_valid_q;
   assign tx_out_tdata  = out_data_q;
   assign tx_out_tkeep  = out_keep_q;
   assign tx_out_tlast  = out_last_q;
   assign tx_out_tuser  = out_user_q;
   assign tx_active     = (state_q == ST_PASS);
   assign pkts_dropped  = dropped_q;
   assign pkts_aborted  = aborted_q;

endmodule

// File: tb/tb_cmac_tx_gate.sv
module tb_cmac_tx_gate;

   localparam int ARM = 16;

   typedef struct packed {
      logic [511:0] data;
      logic [63:0]  keep;
      logic         last;
      logic         user;
   } beat_t;

   logic tx_clk = 1'b0;
   always #5 tx_clk = ~tx_clk;

   logic         tx_resetn;
   logic         aligned_in;
   logic         aligned_off;
   logic [511:0] in_data;
   logic [63:0]  in_keep;
   logic         in_last;
   logic         in_valid;
   logic         rdy_rand;
   logic         stall;
   wire          out_ready = rdy_rand & ~stall;

   logic         in_ready;
   logic [511:0] out_data;
   logic [63:0]  out_keep;
   logic         out_last, out_user, out_valid, active;
   logic [31:0]  dropped, aborted;

   logic         in_ready0;
   logic [511:0] out_data0;
   logic [63:0]  out_keep0;
   logic         out_last0, out_user0, out_valid0, active0;
   logic [31:0]  dropped0, aborted0;

   cmac_tx_gate #(.ARM_CYCLES(ARM), .DROP_WHEN_DOWN(1'b1)) dut (
      .tx_clk(tx_clk), .tx_resetn(tx_resetn), .stat_rx_aligned(aligned_in),
      .tx_in_tdata(in_data), .tx_in_tkeep(in_keep), .tx_in_tlast(in_last),
      .tx_in_tvalid(in_valid), .tx_in_tready(in_ready),
      .tx_out_tdata(out_data), .tx_out_tkeep(out_keep), .tx_out_tlast(out_last),
      .tx_out_tuser(out_user), .tx_out_tvalid(out_valid), .tx_out_tready(out_ready),
      .tx_active(active), .pkts_dropped(dropped), .pkts_aborted(aborted));

   // Second instance: link permanently down, input held off.
   cmac_tx_gate #(.ARM_CYCLES(ARM), .DROP_WHEN_DOWN(1'b0)) dut0 (
      .tx_clk(tx_clk), .tx_resetn(tx_resetn), .stat_rx_aligned(aligned_off),
      .tx_in_tdata(in_data), .tx_in_tkeep(in_keep), .tx_in_tlast(in_last),
      .tx_in_tvalid(in_valid), .tx_in_tready(in_ready0),
      .tx_out_tdata(out_data0), .tx_out_tkeep(out_keep0), .tx_out_tlast(out_last0),
      .tx_out_tuser(out_user0), .tx_out_tvalid(out_valid0), .tx_out_tready(out_ready),
      .tx_active(active0), .pkts_dropped(dropped0), .pkts_aborted(aborted0));

   int    n_cmp = 0;
   int    n_bad = 0;
   beat_t exp_q[$];
   int    exp_dropped = 0;
   int    exp_aborted = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", name, act, req);
      end
   endtask

   task automatic timeout(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timed out", name);
   endtask

   function automatic logic [511:0] rnd512();
      logic [511:0] v;
      for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   function automatic beat_t make_beat(input int idx, input int len);
      beat_t b;
      logic [63:0] ones;
      int n;
      ones   = '1;
      b.data = rnd512();
      b.last = (idx == len - 1);
      b.user = 1'b0;
      n      = $urandom_range(1, 64);
      b.keep = b.last ? (ones >> (64 - n)) : ones;
      return b;
   endfunction

   // Random sink backpressure (~75% ready); stall overrides it.
   initial begin
      rdy_rand = 1'b0;
      forever begin
         @(posedge tx_clk);
         #1 rdy_rand = ($urandom_range(0, 3) != 0);
      end
   end

   // Monitor: pops the scoreboard on every output handshake, checks a
   // stalled beat is held unchanged, and checks the hold-off instance.
   initial begin : monitor
      beat_t cur, held, e;
      logic  was_stall;
      was_stall = 1'b0;
      held      = '0;
      forever begin
         @(negedge tx_clk);
         if (!tx_resetn) begin
            was_stall = 1'b0;
            continue;
         end
         cur = '{data: out_data, keep: out_keep, last: out_last, user: out_user};
         if (was_stall) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            n_cmp++;
            if (cur !== held) begin
               n_bad++;
               $display("FAIL hold_beat: got k=%h l=%b u=%b want k=%h l=%b u=%b",
                        cur.keep, cur.last, cur.user, held.keep, held.last, held.user);
            end
         end
         if (out_valid && out_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_beat: got k=%h l=%b u=%b with nothing expected",
                        cur.keep, cur.last, cur.user);
            end else begin
               e = exp_q.pop_front();
               if (cur !== e) begin
                  n_bad++;
                  $display("FAIL out_beat: got d=%h k=%h l=%b u=%b want d=%h k=%h l=%b u=%b",
                           cur.data, cur.keep, cur.last, cur.user, e.data, e.keep, e.last, e.user);
               end
            end
            was_stall = 1'b0;
         end else if (out_valid) begin
            was_stall = 1'b1;
            held      = cur;
         end else begin
            was_stall = 1'b0;
         end
         if (in_valid) chk("nodrop_tready", 64'(in_ready0), 64'd0);
      end
   end

   // Offer one beat; returns at posedge+1 after the handshake edge.
   task automatic send_beat(input beat_t b, input bit expect_out);
      repeat ($urandom_range(0, 2)) begin
         @(posedge tx_clk);
         #1;
      end
      in_data  = b.data;
      in_keep  = b.keep;
      in_last  = b.last;
      in_valid = 1'b1;
      for (int t = 0; t < 300; t++) begin
         @(negedge tx_clk);
         if (in_ready) begin
            if (expect_out) exp_q.push_back(b);
            @(posedge tx_clk);
            #1 in_valid = 1'b0;
            return;
         end
         @(posedge tx_clk);
         #1;
      end
      in_valid = 1'b0;
      timeout("in_handshake");
   endtask

   task automatic send_frame(input int len, input bit expect_out);
      for (int i = 0; i < len; i++) send_beat(make_beat(i, len), expect_out);
   endtask

   task automatic wait_drain();
      for (int t = 0; t < 1000; t++) begin
         @(negedge tx_clk);
         if (exp_q.size() == 0) begin
            repeat (3) @(posedge tx_clk);
            #1;
            return;
         end
      end
      timeout("drain");
   endtask

   task automatic wait_active();
      for (int t = 0; t < 200; t++) begin
         @(negedge tx_clk);
         if (active) begin
            @(posedge tx_clk);
            #1;
            return;
         end
      end
      timeout("wait_active");
   endtask

   // Abort scenario: beats 1-2 pass, alignment drops, an error beat closes
   // the CMAC frame and beats 3-5 are swallowed.
   task automatic abort_frame(input bit with_stall);
      beat_t b[5];
      beat_t err;
      for (int i = 0; i < 5; i++) b[i] = make_beat(i, 5);
      err = '{data: '0, keep: 64'h1, last: 1'b1, user: 1'b1};
      send_beat(b[0], 1'b1);
      send_beat(b[1], 1'b1);
      if (with_stall) stall = 1'b1;
      aligned_in = 1'b0;
      exp_q.push_back(err);
      repeat (10) begin
         @(posedge tx_clk);
         #1;
      end
      stall = 1'b0;
      chk("active_after_drop", 64'(active), 64'd0);
      for (int i = 2; i < 5; i++) send_beat(b[i], 1'b0);
      exp_aborted++;
      wait_drain();
      chk("pkts_aborted", 64'(aborted), 64'(exp_aborted));
      chk("pkts_dropped_abort", 64'(dropped), 64'(exp_dropped));
      chk("active_after_abort", 64'(active), 64'd0);
   endtask

   initial begin : stim
      int    n;
      beat_t b[4];
      tx_resetn   = 1'b0;
      aligned_in  = 1'b0;
      aligned_off = 1'b0;
      in_valid    = 1'b0;
      in_data     = '0;
      in_keep     = '0;
      in_last     = 1'b0;
      stall       = 1'b0;

      // Reset state
      repeat (3) @(posedge tx_clk);
      @(negedge tx_clk);
      chk("rst_in_tready",  64'(in_ready),  64'd0);
      chk("rst_out_tvalid", 64'(out_valid), 64'd0);
      chk("rst_out_tdata",  64'(|out_data), 64'd0);
      chk("rst_out_tkeep",  out_keep,       64'd0);
      chk("rst_out_tlast",  64'(out_last),  64'd0);
      chk("rst_out_tuser",  64'(out_user),  64'd0);
      chk("rst_active",     64'(active),    64'd0);
      chk("rst_dropped",    64'(dropped),   64'd0);
      chk("rst_aborted",    64'(aborted),   64'd0);
      @(posedge tx_clk);
      #1 tx_resetn = 1'b1;

      // Link down: four frames accepted and discarded, nothing out.
      for (int f = 0; f < 4; f++) send_frame($urandom_range(1, 4), 1'b0);
      exp_dropped += 4;
      repeat (4) begin
         @(posedge tx_clk);
         #1;
      end
      chk("down_dropped", 64'(dropped), 64'(exp_dropped));
      chk("down_out_tvalid", 64'(out_valid), 64'd0);

      // Arm timing: 3 synchroniser edges, one DOWN->ARM edge, ARM cycles of
      // counting; tx_active is first seen after edge 20 from the change.
      aligned_in = 1'b1;
      n = 0;
      while (n < 100) begin
         @(posedge tx_clk);
         n++;
         @(negedge tx_clk);
         if (active) break;
      end
      chk("arm_edges", 64'(n), 64'(ARM + 4));
      @(posedge tx_clk);
      #1;

      // Passing: random frames under random backpressure.
      for (int f = 0; f < 8; f++) send_frame($urandom_range(1, 6), 1'b1);
      wait_drain();
      chk("pass_active", 64'(active), 64'd1);
      chk("pass_dropped", 64'(dropped), 64'(exp_dropped));

      // Mid-frame loss, free-flowing sink.
      abort_frame(1'b0);

      // Re-arm, one good frame, then mid-frame loss with a stalled sink.
      aligned_in = 1'b1;
      wait_active();
      send_frame(3, 1'b1);
      abort_frame(1'b1);

      // Alignment returns while the app is mid-frame in DOWN.
      for (int i = 0; i < 4; i++) b[i] = make_beat(i, 4);
      send_beat(b[0], 1'b0);
      send_beat(b[1], 1'b0);
      aligned_in = 1'b1;
      repeat (40) begin
         @(posedge tx_clk);
         #1;
      end
      chk("arm_hold_mid", 64'(active), 64'd0);
      send_beat(b[2], 1'b0);
      send_beat(b[3], 1'b0);
      exp_dropped++;
      chk("arm_open_at_eof", 64'(active), 64'd1);
      send_frame(3, 1'b1);
      wait_drain();
      chk("final_dropped", 64'(dropped), 64'(exp_dropped));
      chk("final_aborted", 64'(aborted), 64'(exp_aborted));
      chk("queue_empty", 64'(exp_q.size()), 64'd0);

      // Hold-off instance never accepted, counted or emitted anything.
      chk("hold_dropped",  64'(dropped0),   64'd0);
      chk("hold_aborted",  64'(aborted0),   64'd0);
      chk("hold_active",   64'(active0),    64'd0);
      chk("hold_tvalid",   64'(out_valid0), 64'd0);
      chk("hold_outregs",  64'(|{out_data0, out_keep0, out_last0, out_user0}), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1);
   end

endmodule
